// File: rtl/adt7320_pkg.sv
// adt7320_pkg: ADT7320 register map, read command, register widths and poller state encoding
package adt7320_pkg;

    localparam logic [2:0] REG_STATUS = 3'd0;
    localparam logic [2:0] REG_CONFIG = 3'd1;
    localparam logic [2:0] REG_TEMP   = 3'd2;
    localparam logic [2:0] REG_ID     = 3'd3;
    localparam logic [2:0] REG_TCRIT  = 3'd4;
    localparam logic [2:0] REG_THYST  = 3'd5;
    localparam logic [2:0] REG_THIGH  = 3'd6;
    localparam logic [2:0] REG_TLOW   = 3'd7;

    localparam logic [7:0] READ_CMD = 8'h40;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    function automatic logic [4:0] reg_bits(input logic [2:0] a);
        case (a)
            REG_TEMP, REG_TCRIT, REG_THIGH, REG_TLOW:  return 5'd16;
            REG_STATUS, REG_CONFIG, REG_ID, REG_THYST: return 5'd8;
        endcase
    endfunction

endpackage

// File: rtl/adt7320_spi_xfer.sv
// adt7320_spi_xfer: one mode-3 SPI read (command byte out, nbits data in), done strobes on the last clk
module adt7320_spi_xfer
    import adt7320_pkg::*;
#(
    parameter int SCLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        go,
    input  logic [2:0]  addr,
    input  logic [4:0]  nbits,
    input  logic        dout,
    output logic        sclk,
    output logic        din,
    output logic [15:0] rdata,
    output logic        done
);
    localparam int CW = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;

    logic          active;
    logic [CW-1:0] cnt;
    logic [4:0]    bitn;
    logic [7:0]    sr;
    logic [7:0]    cmd;
    logic          tick;

    assign cmd  = READ_CMD | {2'b00, addr, 3'b000};
    assign tick = cnt == CW'(SCLK_DIV - 1);
    assign done = active && sclk && tick && bitn == 5'd7 + nbits;

    // half-period divider: din moves on sclk fall, dout captured on sclk rise for data bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active <= 1'b0;
            cnt    <= '0;
            bitn   <= '0;
            sr     <= '0;
            sclk   <= 1'b1;
            din    <= 1'b0;
            rdata  <= '0;
        end else if (go) begin
            active <= 1'b1;
            cnt    <= '0;
            bitn   <= '0;
            sclk   <= 1'b0;
            din    <= cmd[7];
            sr     <= {cmd[6:0], 1'b0};
            rdata  <= '0;
        end else if (active) begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                if (!sclk) begin
                    sclk <= 1'b1;
                    if (bitn >= 5'd8) rdata <= {rdata[14:0], dout};
                end else if (done) begin
                    active <= 1'b0;
                end else begin
                    sclk <= 1'b0;
                    bitn <= bitn + 1'b1;
                    din  <= sr[7];
                    sr   <= {sr[6:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: rtl/adt7320_poller.sv
// adt7320_poller: sweeps NCHAN ADT7320 sensors on a shared SPI bus; optional ADT7320_ALARM_EN adds alarm_limit compare
module adt7320_poller
    import adt7320_pkg::*;
#(
    parameter int NCHAN    = 4,
    parameter int SCLK_DIV = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [2:0]          addr,
    input  logic [NCHAN-1:0]    chan_mask,
    input  logic                enable,
    input  logic                start,
`ifdef ADT7320_ALARM_EN
    input  logic [15:0]         alarm_limit,
`endif
    output logic [NCHAN*16-1:0] result,
    output logic [NCHAN-1:0]    valid,
    output logic                busy,
    output logic                done,
    output logic [NCHAN-1:0]    alarm,
    output logic [NCHAN-1:0]    cs_n,
    output logic                sclk,
    output logic                din,
    input  logic                dout
);
    localparam int CW = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;

    logic [2:0]       state;
    logic [CW-1:0]    cnt;
    logic [3:0]       ch, first, nxt;
    logic             more;
    logic [NCHAN-1:0] mask_q;
    logic [2:0]       addr_q;
    logic [15:0]      rdata;
    logic             xfer_done, tick, go, store, sel;

    assign tick  = cnt == CW'(SCLK_DIV - 1);
    assign go    = state == S_SETUP && tick;
    assign store = state == S_HOLD && tick;
    assign sel   = state == S_SETUP || state == S_SHIFT || state == S_HOLD;

    adt7320_spi_xfer #(.SCLK_DIV(SCLK_DIV)) u_xfer (
        .clk     (clk),
        .reset_n (reset_n),
        .go      (go),
        .addr    (addr_q),
        .nbits   (reg_bits(addr_q)),
        .dout    (dout),
        .sclk    (sclk),
        .din     (din),
        .rdata   (rdata),
        .done    (xfer_done)
    );

    // lowest enabled channel for a new sweep, and next enabled channel above the current one
    always_comb begin
        first = '0;
        nxt   = '0;
        more  = 1'b0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (chan_mask[i]) first = 4'(i);
            if (mask_q[i] && 4'(i) > ch) begin
                nxt  = 4'(i);
                more = 1'b1;
            end
        end
    end

    // one chip select low from SETUP through HOLD of the active channel
    always_comb begin
        cs_n = '1;
        for (int i = 0; i < NCHAN; i++) if (sel && ch == 4'(i)) cs_n[i] = 1'b0;
    end

    // channel sequencer: SETUP/HOLD/GAP are SCLK_DIV clks each, SHIFT waits for the shifter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            ch     <= '0;
            mask_q <= '0;
            addr_q <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if ((start || enable) && |chan_mask) begin
                    state  <= S_SETUP;
                    cnt    <= '0;
                    ch     <= first;
                    mask_q <= chan_mask;
                    addr_q <= addr;
                    busy   <= 1'b1;
                end
                S_SETUP: begin
                    cnt <= tick ? '0 : cnt + 1'b1;
                    if (tick) state <= S_SHIFT;
                end
                S_SHIFT: if (xfer_done) begin
                    state <= S_HOLD;
                    cnt   <= '0;
                end
                S_HOLD: begin
                    cnt <= tick ? '0 : cnt + 1'b1;
                    if (tick) state <= S_GAP;
                end
                S_GAP: begin
                    cnt <= tick ? '0 : cnt + 1'b1;
                    if (tick) begin
                        state <= more ? S_SETUP : S_IDLE;
                        ch    <= more ? nxt : ch;
                        busy  <= more;
                        done  <= !more;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // result and sticky valid written on the last HOLD clk of each transaction
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result <= '0;
            valid  <= '0;
        end else if (store) begin
            for (int i = 0; i < NCHAN; i++) begin
                if (ch == 4'(i)) begin
                    result[16*i +: 16] <= rdata;
                    valid[i]           <= 1'b1;
                end
            end
        end
    end

`ifdef ADT7320_ALARM_EN
    // alarm follows each temperature result against the signed limit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alarm <= '0;
        end else if (store && addr_q == REG_TEMP) begin
            for (int i = 0; i < NCHAN; i++)
                if (ch == 4'(i)) alarm[i] <= $signed(rdata) > $signed(alarm_limit);
        end
    end
`else
    assign alarm = '0;
`endif

endmodule

// File: tb/tb_adt7320_poller.sv
// tb_adt7320_poller: directed + random sweeps against behavioural ADT7320 sensors and a transaction-level model
module tb_adt7320_poller;
    localparam int NCHAN = 4;
    localparam int D     = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  addr = '0;
    logic [3:0]  chan_mask = '0;
    logic        enable = 1'b0;
    logic        start = 1'b0;
    logic        dout = 1'b0;
    logic [63:0] result;
    logic [3:0]  valid, alarm, cs_n;
    logic        busy, done, sclk, din;
`ifdef ADT7320_ALARM_EN
    logic [15:0] alarm_limit = 16'h1000;
`endif

    adt7320_poller #(.NCHAN(NCHAN), .SCLK_DIV(D)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .addr        (addr),
        .chan_mask   (chan_mask),
        .enable      (enable),
        .start       (start),
`ifdef ADT7320_ALARM_EN
        .alarm_limit (alarm_limit),
`endif
        .result      (result),
        .valid       (valid),
        .busy        (busy),
        .done        (done),
        .alarm       (alarm),
        .cs_n        (cs_n),
        .sclk        (sclk),
        .din         (din),
        .dout        (dout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [15:0] regs [4][8];
    logic [15:0] exp_res [4];
    logic [3:0]  exp_valid = '0;
    logic [3:0]  exp_alarm = '0;

    int          busy_cyc = 0, done_cnt = 0, viol = 0, cmd_err = 0, sclk_low = 0;
    logic [3:0]  seen = '0;
    int          bitc = 0, act = 0;
    logic        psclk = 1'b1;
    logic [7:0]  cmd = '0;
    logic [15:0] tx = '0;

    function automatic bit is16(input logic [2:0] a);
        return a == 3'd2 || a == 3'd4 || a == 3'd6 || a == 3'd7;
    endfunction

    function automatic int xlen(input logic [2:0] a);
        return D * (3 + 2 * (8 + (is16(a) ? 16 : 8)));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // bus monitor plus behavioural sensors: one shared dout, selected by whichever cs_n is low
    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            bitc = 0;
        end else begin
            if ($countones(~cs_n) > 1) viol++;
            if (sclk !== psclk && &cs_n) viol++;
            if (!sclk) sclk_low++;
            busy_cyc += int'(busy);
            done_cnt += int'(done);
            seen |= ~cs_n;
            if (&cs_n) begin
                bitc = 0;
            end else begin
                for (int i = 0; i < 4; i++) if (!cs_n[i]) act = i;
                if (sclk && !psclk) begin
                    if (bitc >= 8 && din !== 1'b0) viol++;
                    if (bitc < 8) cmd = {cmd[6:0], din};
                    bitc++;
                    if (bitc == 8) begin
                        if (cmd !== {2'b01, addr, 3'b000}) cmd_err++;
                        tx = is16(cmd[5:3]) ? regs[act][cmd[5:3]] : {regs[act][cmd[5:3]][7:0], 8'h00};
                    end
                end else if (!sclk && psclk && bitc >= 8) begin
                    dout = tx[15];
                    tx = {tx[14:0], 1'b0};
                end
            end
        end
        psclk = sclk;
    end

    task automatic apply_model(input logic [3:0] m, input logic [2:0] a);
        for (int k = 0; k < 4; k++) begin
            if (m[k]) begin
                exp_res[k]   = is16(a) ? regs[k][a] : {8'h00, regs[k][a][7:0]};
                exp_valid[k] = 1'b1;
`ifdef ADT7320_ALARM_EN
                if (a == 3'd2) exp_alarm[k] = $signed(exp_res[k]) > $signed(alarm_limit);
`endif
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_result"}, result, {exp_res[3], exp_res[2], exp_res[1], exp_res[0]});
        chk({tag, "_valid"}, valid, exp_valid);
        chk({tag, "_alarm"}, alarm, exp_alarm);
    endtask

    task automatic clear_mon();
        busy_cyc = 0; done_cnt = 0; viol = 0; cmd_err = 0; sclk_low = 0; seen = '0;
    endtask

    task automatic sweep(input logic [3:0] m, input logic [2:0] a, input string tag);
        chan_mask = m;
        addr = a;
        clear_mon();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) @(negedge clk);
        chk({tag, "_done_seen"}, done, 1'b1);
        @(negedge clk);
        apply_model(m, a);
        check_outputs(tag);
        chk({tag, "_busy_clks"}, busy_cyc, $countones(m) * xlen(a));
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_bus_rules"}, viol, 0);
        chk({tag, "_cmd"}, cmd_err, 0);
        chk({tag, "_cs_used"}, seen, m);
        chk({tag, "_busy_end"}, busy, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            exp_res[k] = '0;
            for (int r = 0; r < 8; r++) regs[k][r] = 16'($urandom);
            regs[k][3] = 16'h00C3;
        end
        regs[0][2] = 16'h0C80; regs[1][2] = 16'h1900; regs[2][2] = 16'hF380; regs[3][2] = 16'h0000;

        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs_n, 4'hF);
        chk("rst_sclk", sclk, 1'b1);
        chk("rst_din", din, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        check_outputs("rst");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        sweep(4'b1111, 3'd2, "t1");
        chk("t1_words", result, 64'h0000_F380_1900_0C80);

        sweep(4'b0101, 3'd3, "t2");
        chk("t2_res0", result[15:0], 16'h00C3);
        chk("t2_res2", result[47:32], 16'h00C3);

        chan_mask = 4'b0000;
        clear_mon();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        chk("t3_busy", busy_cyc, 0);
        chk("t3_done", done_cnt, 0);
        chk("t3_cs", seen, 4'h0);
        chk("t3_sclk_low", sclk_low, 0);
        check_outputs("t3");

        chan_mask = 4'b0011;
        addr = 3'd3;
        clear_mon();
        enable = 1'b1;
        repeat ((5 * (2 * xlen(3'd3) + 1)) / 2) @(negedge clk);
        enable = 1'b0;
        repeat (800) @(negedge clk);
        apply_model(4'b0011, 3'd3);
        chk("t4_done_cnt", done_cnt, 3);
        chk("t4_busy_clks", busy_cyc, 3 * 2 * xlen(3'd3));
        chk("t4_busy", busy, 1'b0);
        chk("t4_cs", cs_n, 4'hF);
        chk("t4_bus_rules", viol, 0);
        check_outputs("t4");

        for (int n = 0; n < 6; n++) begin
            for (int k = 0; k < 4; k++) for (int r = 0; r < 8; r++) regs[k][r] = 16'($urandom);
            sweep(4'($urandom_range(1, 15)), 3'($urandom_range(0, 7)), "rnd");
        end

        chan_mask = 4'b1111;
        addr = 3'd2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3000 && !(!cs_n[1] && !sclk); i++) @(negedge clk);
        chk("t5_in_shift", {cs_n[1], sclk}, 2'b00);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_cs_n", cs_n, 4'hF);
        chk("t5_sclk", sclk, 1'b1);
        chk("t5_result", result, 64'h0);
        chk("t5_valid", valid, 4'h0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_alarm", alarm, 4'h0);
        for (int k = 0; k < 4; k++) exp_res[k] = '0;
        exp_valid = '0;
        exp_alarm = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        regs[0][2] = 16'h0C80; regs[1][2] = 16'h1900;
        sweep(4'b0011, 3'd2, "t6");
`ifdef ADT7320_ALARM_EN
        chk("t6_alarm_fixed", alarm, 4'b0010);
`else
        chk("t6_alarm_fixed", alarm, 4'b0000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
